// File: rtl/mult_share_sequencer.sv
// Round-robin sequencer that time-shares one signed add-shift multiplier datapath
// between NREQ requesters and generates its Moore control strobes.
module mult_share_sequencer #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [NREQ-1:0] req,
    input  logic            M,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] done,
    output logic            busy,
    output logic            ClearA,
    output logic            LoadB,
    output logic            LoadA,
    output logic            Add,
    output logic            Sub,
    output logic            Shift
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = $clog2(NREQ);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SUB   = 3'd4,
        S_SHIFT = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   win_s;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q;
    logic            busy_q, clear_a_q, load_b_q, load_a_q, add_q, sub_q, shift_q;

    // First active requester strictly after the pointer, searching circularly.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] idx;
        logic          found;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = PW'((int'(p) + i) % NREQ);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign win_s = rr_pick(req, ptr_q);

    // Next-state, counter, pointer and grant logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
                    ptr_d   = win_s;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_TEST;
            end
            S_TEST: begin
                if (!M) begin
                    state_d = S_SHIFT;
                end else if (cnt_q == LAST) begin
                    state_d = S_SUB;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_ADD:   state_d = S_SHIFT;
            S_SUB:   state_d = S_SHIFT;
            S_SHIFT: begin
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_TEST;
                end
            end
            S_DONE: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; strobes are registered copies of the next-state decode.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ptr_q     <= PW'(NREQ - 1);
            grant_q   <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            clear_a_q <= 1'b0;
            load_b_q  <= 1'b0;
            load_a_q  <= 1'b0;
            add_q     <= 1'b0;
            sub_q     <= 1'b0;
            shift_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            done_q    <= (state_d == S_DONE) ? grant_d : '0;
            busy_q    <= (state_d != S_IDLE);
            clear_a_q <= (state_d == S_LOAD);
            load_b_q  <= (state_d == S_LOAD);
            load_a_q  <= (state_d == S_ADD) || (state_d == S_SUB);
            add_q     <= (state_d == S_ADD);
            sub_q     <= (state_d == S_SUB);
            shift_q   <= (state_d == S_SHIFT);
        end
    end

    assign grant  = grant_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign ClearA = clear_a_q;
    assign LoadB  = load_b_q;
    assign LoadA  = load_a_q;
    assign Add    = add_q;
    assign Sub    = sub_q;
    assign Shift  = shift_q;

endmodule

// File: tb/tb_mult_share_sequencer.sv
// Directed bench for mult_share_sequencer: a WIDTH=8 instance for arbitration/latency
// cases and a WIDTH=4 instance for a mixed multiplier bit pattern.
module tb_mult_share_sequencer;

    logic       clk;
    logic       Reset;
    logic [1:0] req8, req4;
    logic       M8, M4;
    logic [1:0] grant8, done8, grant4, done4;
    logic       busy8, clr8, ldb8, lda8, add8, sub8, sh8;
    logic       busy4, clr4, ldb4, lda4, add4, sub4, sh4;

    int n_checks = 0;
    int n_fail   = 0;

    logic       use4_s;
    logic [3:0] pat4;
    logic [1:0] o_grant, o_done;
    logic       o_busy, o_clr, o_ldb, o_lda, o_add, o_sub, o_sh;

    mult_share_sequencer #(.WIDTH(8), .NREQ(2)) dut8 (
        .Clk(clk), .Reset(Reset), .req(req8), .M(M8), .grant(grant8), .done(done8),
        .busy(busy8), .ClearA(clr8), .LoadB(ldb8), .LoadA(lda8), .Add(add8), .Sub(sub8), .Shift(sh8)
    );

    mult_share_sequencer #(.WIDTH(4), .NREQ(2)) dut4 (
        .Clk(clk), .Reset(Reset), .req(req4), .M(M4), .grant(grant4), .done(done4),
        .busy(busy4), .ClearA(clr4), .LoadB(ldb4), .LoadA(lda4), .Add(add4), .Sub(sub4), .Shift(sh4)
    );

    assign o_grant = use4_s ? grant4 : grant8;
    assign o_done  = use4_s ? done4  : done8;
    assign o_busy  = use4_s ? busy4  : busy8;
    assign o_clr   = use4_s ? clr4   : clr8;
    assign o_ldb   = use4_s ? ldb4   : ldb8;
    assign o_lda   = use4_s ? lda4   : lda8;
    assign o_add   = use4_s ? add4   : add8;
    assign o_sub   = use4_s ? sub4   : sub8;
    assign o_sh    = use4_s ? sh4    : sh8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        req8  = 2'b00;
        req4  = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    // Waits for LOAD, then follows one operation to its done pulse and the IDLE cycle after.
    task automatic observe_op(input bit use4, input bit drop_on_shift, input bit release_at_done,
                              output int wait_cyc, output int lat, output int nsh, output int nadd,
                              output int nsub, output int nla, output int sub_cyc,
                              output logic [1:0] g, output logic [1:0] dv);
        int idx;
        use4_s = use4;
        wait_cyc = 0; lat = 0; nsh = 0; nadd = 0; nsub = 0; nla = 0; sub_cyc = -1;
        g = 2'b00; dv = 2'b00; idx = 0;
        #1;
        while (!o_clr && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!o_clr) begin
            check_eq("load_timeout", 32'd0, 32'd1);
            return;
        end
        g = o_grant;
        check_eq("loadb_at_load", {31'd0, o_ldb}, 32'd1);
        while (o_done == 2'b00 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (o_add) nadd++;
            if (o_sub) begin nsub++; sub_cyc = lat; end
            if (o_lda) nla++;
            if (o_sh) begin
                nsh++;
                if (drop_on_shift) req8 = 2'b00;
                if (use4 && idx < 3) begin
                    idx++;
                    M4 = pat4[idx];
                end
            end
        end
        if (o_done == 2'b00) begin
            check_eq("done_timeout", 32'd0, 32'd1);
            return;
        end
        dv = o_done;
        check_eq("grant_with_done", {30'd0, o_grant}, {30'd0, g});
        if (release_at_done) begin
            req8 = 2'b00;
            req4 = 2'b00;
        end
        @(negedge clk);
        check_eq("idle_busy", {31'd0, o_busy}, 32'd0);
        check_eq("idle_grant", {30'd0, o_grant}, 32'd0);
        check_eq("idle_done", {30'd0, o_done}, 32'd0);
    endtask

    int wc, lat, nsh, nadd, nsub, nla, scyc;
    logic [1:0] g, dv;
    logic [1:0] exp_g;
    bit found;

    initial begin
        Reset = 1'b1; req8 = 2'b00; req4 = 2'b00; M8 = 1'b0; M4 = 1'b0;
        use4_s = 1'b0; pat4 = 4'b1101;

        // 1: reset state, then all-zero multiplier
        do_reset();
        check_eq("rst_busy", {31'd0, busy8}, 32'd0);
        check_eq("rst_grant", {30'd0, grant8}, 32'd0);
        check_eq("rst_done", {30'd0, done8}, 32'd0);
        check_eq("rst_strobes", {26'd0, clr8, ldb8, lda8, add8, sub8, sh8}, 32'd0);
        Reset = 1'b0; M8 = 1'b0; req8 = 2'b01;
        observe_op(1'b0, 1'b0, 1'b1, wc, lat, nsh, nadd, nsub, nla, scyc, g, dv);
        check_eq("t1_grant", {30'd0, g}, 32'd1);
        check_eq("t1_done", {30'd0, dv}, 32'd1);
        check_eq("t1_latency", lat, 32'd17);
        check_eq("t1_shifts", nsh, 32'd8);
        check_eq("t1_addsub", nadd + nsub, 32'd0);

        // 2: all-ones multiplier
        M8 = 1'b1; req8 = 2'b01;
        observe_op(1'b0, 1'b0, 1'b1, wc, lat, nsh, nadd, nsub, nla, scyc, g, dv);
        check_eq("t2_latency", lat, 32'd25);
        check_eq("t2_adds", nadd, 32'd7);
        check_eq("t2_subs", nsub, 32'd1);
        check_eq("t2_loada", nla, 32'd8);
        check_eq("t2_shifts", nsh, 32'd8);
        check_eq("t2_sub_cycle", scyc, 32'd23);
        check_eq("t2_done", {30'd0, dv}, 32'd1);

        // 3: both requesting from reset, alternating service
        do_reset();
        Reset = 1'b0; M8 = 1'b0; req8 = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            observe_op(1'b0, 1'b0, 1'b0, wc, lat, nsh, nadd, nsub, nla, scyc, g, dv);
            check_eq($sformatf("t3_grant%0d", i), {30'd0, g}, {30'd0, exp_g});
            check_eq($sformatf("t3_done%0d", i), {30'd0, dv}, {30'd0, exp_g});
            check_eq($sformatf("t3_idle_gap%0d", i), wc, 32'd1);
            check_eq($sformatf("t3_latency%0d", i), lat, 32'd17);
        end

        // 4: reset during an ADD cycle
        do_reset();
        Reset = 1'b0; M8 = 1'b1; req8 = 2'b01;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (add8) found = 1'b1;
        end
        check_eq("t4_add_seen", {31'd0, found}, 32'd1);
        Reset = 1'b1; req8 = 2'b00;
        @(negedge clk);
        check_eq("t4_busy", {31'd0, busy8}, 32'd0);
        check_eq("t4_grant", {30'd0, grant8}, 32'd0);
        check_eq("t4_done", {30'd0, done8}, 32'd0);
        check_eq("t4_strobes", {26'd0, clr8, ldb8, lda8, add8, sub8, sh8}, 32'd0);
        Reset = 1'b0; req8 = 2'b10;
        observe_op(1'b0, 1'b0, 1'b1, wc, lat, nsh, nadd, nsub, nla, scyc, g, dv);
        check_eq("t4_grant_after", {30'd0, g}, 32'd2);
        check_eq("t4_done_after", {30'd0, dv}, 32'd2);
        check_eq("t4_latency", lat, 32'd25);

        // 5: request dropped mid-operation
        do_reset();
        Reset = 1'b0; M8 = 1'b0; req8 = 2'b01;
        observe_op(1'b0, 1'b1, 1'b0, wc, lat, nsh, nadd, nsub, nla, scyc, g, dv);
        check_eq("t5_done", {30'd0, dv}, 32'd1);
        check_eq("t5_latency", lat, 32'd17);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("t5_idle%0d", i), {30'd0, busy8, clr8}, 32'd0);
        end

        // 6: WIDTH=4, multiplier bits 1,0,1,1 LSB first
        do_reset();
        Reset = 1'b0; M4 = pat4[0]; req4 = 2'b01;
        observe_op(1'b1, 1'b0, 1'b1, wc, lat, nsh, nadd, nsub, nla, scyc, g, dv);
        check_eq("t6_grant", {30'd0, g}, 32'd1);
        check_eq("t6_done", {30'd0, dv}, 32'd1);
        check_eq("t6_latency", lat, 32'd12);
        check_eq("t6_adds", nadd, 32'd2);
        check_eq("t6_subs", nsub, 32'd1);
        check_eq("t6_shifts", nsh, 32'd4);
        check_eq("t6_sub_cycle", scyc, 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
